rr_hold_arbiter: RTL and testbench
==================================

RR_HOLD_ARBITER -- requirements
Module: rr_hold_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2 or more).
REQ-002 SHALL have parameter MAX_HOLD, default 8, maximum consecutive grant cycles before preemption (1 or more).
REQ-003 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port i_cg, input, 1: clock-gate enable; state updates only when high.
REQ-006 SHALL have port i_req, input, N_REQ: request vector, one bit per requester.
REQ-007 SHALL have port o_gnt, output, N_REQ: registered grant vector, zero-hot or onehot.
REQ-008 SHALL have port o_gntIdx, output, $clog2(N_REQ): index of the set o_gnt bit; 0 when none is set.
REQ-009 SHALL have port o_gntValid, output, 1: high exactly when o_gnt is nonzero.

Function
REQ-010 SHALL implement the FSM states IDLE (no grant) and GRANT (one grant held).
REQ-011 SHALL hold o_gnt to at most one set bit at all times.
REQ-012 SHALL keep a priority pointer ptr in 0..N_REQ-1.
REQ-013 SHALL select the winner as the first set i_req bit at or after ptr, in increasing index order, wrapping from N_REQ-1 to 0.
REQ-014 SHALL apply a grant one cycle after selection: IDLE with any i_req high moves to GRANT and loads o_gnt with the winner on the next edge.
REQ-015 SHALL, on each edge where a grant is loaded for index k, set ptr to (k+1) mod N_REQ.
REQ-016 SHALL, on each edge where a grant is loaded, clear holdCnt to 0.
REQ-017 SHALL keep o_gnt unchanged in GRANT while the granted i_req bit stays high and holdCnt < MAX_HOLD-1.
REQ-018 SHALL increment holdCnt on each such hold edge.
REQ-019 SHALL, in GRANT when the granted i_req bit is low, load the next winner on that edge if any other request is high (no idle bubble between owners).
REQ-020 SHALL, in the same case with no other request high, clear o_gnt and move to IDLE.
REQ-021 SHALL, in GRANT when holdCnt == MAX_HOLD-1 and another requester is high, preempt: load the next winner and clear holdCnt.
REQ-022 SHALL, when holdCnt == MAX_HOLD-1 and no other requester is high, keep the current grant and saturate holdCnt at MAX_HOLD-1.
REQ-023 SHALL size holdCnt at $clog2(MAX_HOLD+1) bits with no wrap-around.
REQ-024 SHALL derive o_gntIdx combinationally from registered o_gnt, with zero extra latency.
REQ-025 SHALL derive o_gntValid combinationally from registered o_gnt, with zero extra latency.
REQ-026 SHALL, when i_cg is low, freeze state, ptr, holdCnt and o_gnt regardless of i_req.
REQ-027 SHALL ignore requests from indices that are not granted, except for winner selection.
REQ-028 SHALL NOT let a re-raised request from the current owner bypass rotation after it has dropped.

Reset
REQ-029 SHALL, while i_rst_n is low, asynchronously force state=IDLE, o_gnt=0, o_gntIdx=0, o_gntValid=0, ptr=0 and holdCnt=0.
REQ-030 SHALL, on reset assertion mid-grant, drop the grant immediately without waiting for a clock edge.
REQ-031 SHALL, after reset release, make the first grant no earlier than the first rising edge with i_cg high.

Structure
REQ-032 SHALL define state encodings as module-local constants; no shared package is required.
REQ-033 SHALL instantiate onehotIdx (WIDTH=N_REQ) as its single sub-module, converting o_gnt into o_gntIdx and o_gntValid.
REQ-034 SHALL be implementable in 120-400 lines of RTL and be fully synchronous apart from the reset.

Verification (N_REQ=4, MAX_HOLD=3, i_cg=1 unless stated)
REQ-035 SHALL cover: reset, then i_req=4'b0101 at cycle 0 -> o_gnt=0001, o_gntIdx=0 at cycle 1; drop req0 -> o_gnt=0100, o_gntIdx=2 next cycle.
REQ-036 SHALL cover: i_req=4'b1111 held -> grants 0,1,2,3,0 each lasting 3 cycles (preemption at MAX_HOLD).
REQ-037 SHALL cover: i_req=4'b0010 held alone for 10 cycles -> o_gnt=0010 throughout, holdCnt saturated at 2.
REQ-038 SHALL cover: owner drops with no other request -> o_gnt=0, o_gntValid=0 next cycle; state IDLE.
REQ-039 SHALL cover: i_cg=0 for 5 cycles while i_req changes -> o_gnt unchanged; rotation resumes from the frozen ptr.
REQ-040 SHALL cover: i_rst_n pulsed low mid-grant -> o_gnt=0 immediately, ptr=0; i_req=4'b1000 after release -> grant 3 one cycle later.

Source files
------------

// File: rtl/rr_hold_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rr_hold_arbiter_pkg
//   Shared defaults and a small helper for the round-robin hold arbiter.
//   Contents:
//     RRH_DEF_N_REQ    - default number of requesters
//     RRH_DEF_MAX_HOLD - default maximum consecutive grant cycles
//     rr_next()        - wrap-around increment used to advance the pointer
// ----------------------------------------------------------------------------
package rr_hold_arbiter_pkg;

    localparam int unsigned RRH_DEF_N_REQ    = 4;
    localparam int unsigned RRH_DEF_MAX_HOLD = 8;

    // (k + 1) mod n without a divider.
    function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
        return (k + 1 >= n) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/onehotIdx.sv
// ----------------------------------------------------------------------------
// onehotIdx
//   Converts a zero-hot / one-hot vector into the index of its set bit plus a
//   valid flag. Purely combinational.
//   Ports:
//     onehot [WIDTH-1:0]         - input vector, at most one bit set
//     idx    [$clog2(WIDTH)-1:0] - index of the set bit, 0 when none set
//     valid                      - high when any bit is set
// ----------------------------------------------------------------------------
module onehotIdx #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         onehot,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     valid
);

    localparam int IW = $clog2(WIDTH);

    // OR-reduction of indices: correct because at most one bit is set.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) idx = idx | IW'(i);
        end
    end

    assign valid = |onehot;

endmodule

// File: rtl/rr_hold_arbiter.sv
// ----------------------------------------------------------------------------
// rr_hold_arbiter
//   Round-robin arbiter with a bounded hold. A granted requester keeps the
//   grant while its request stays high, up to MAX_HOLD cycles when others are
//   waiting; alone, it keeps the grant indefinitely. Grants are registered.
//   Ports:
//     i_clk       - clock, state updates on rising edge
//     i_rst_n     - asynchronous active-low reset
//     i_cg        - clock-gate enable; state frozen when low
//     i_req       - request vector [N_REQ-1:0]
//     o_gnt       - registered one-hot/zero-hot grant [N_REQ-1:0]
//     o_gntIdx    - index of the granted requester, 0 when none
//     o_gntValid  - high when o_gnt is nonzero
// ----------------------------------------------------------------------------
module rr_hold_arbiter
    import rr_hold_arbiter_pkg::*;
#(
    parameter int N_REQ    = RRH_DEF_N_REQ,
    parameter int MAX_HOLD = RRH_DEF_MAX_HOLD
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_cg,
    input  logic [N_REQ-1:0]         i_req,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_gntIdx,
    output logic                     o_gntValid
);

    localparam int PW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [N_REQ-1:0] ONE       = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [0:0]       state;
    logic [PW-1:0]    ptr;
    logic [HW-1:0]    hold_cnt;

    logic [N_REQ-1:0] cand;
    logic             own_req;
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic             do_load;
    logic             do_drop;
    logic             do_hold;

    // The current owner is never a candidate: when it drops, a late re-raise
    // must wait its turn, and on preemption it must yield to the others.
    assign cand    = i_req & ~o_gnt;
    assign own_req = |(i_req & o_gnt);

    // First candidate at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!win_found && cand[PW'((int'(ptr) + i) % N_REQ)]) begin
                win_found = 1'b1;
                win_idx   = PW'((int'(ptr) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        do_load = 1'b0;
        do_drop = 1'b0;
        do_hold = 1'b0;
        if (state == ST_IDLE) begin
            do_load = win_found;
        end else if (!own_req) begin
            do_load = win_found;
            do_drop = !win_found;
        end else if (hold_cnt < HOLD_LAST) begin
            do_hold = 1'b1;
        end else begin
            // Hold budget spent: yield only if someone else is waiting,
            // otherwise stay and leave hold_cnt saturated.
            do_load = win_found;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            o_gnt    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else if (i_cg) begin
            if (do_load) begin
                state    <= ST_GRANT;
                o_gnt    <= ONE << win_idx;
                ptr      <= PW'(rr_next(32'(win_idx), N_REQ));
                hold_cnt <= '0;
            end else if (do_drop) begin
                state    <= ST_IDLE;
                o_gnt    <= '0;
            end else if (do_hold) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    onehotIdx #(.WIDTH(N_REQ)) u_idx (
        .onehot (o_gnt),
        .idx    (o_gntIdx),
        .valid  (o_gntValid)
    );

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_hold_arbiter
//   Bench for rr_hold_arbiter (N_REQ=4, MAX_HOLD=3). A reference model tracks
//   the owner as an integer and picks winners by scanning from the pointer.
// ----------------------------------------------------------------------------
module tb_rr_hold_arbiter;

    localparam int N  = 4;
    localparam int MH = 3;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_cg = 1'b1;
    logic [3:0] i_req = '0;
    logic [3:0] o_gnt;
    logic [1:0] o_gntIdx;
    logic       o_gntValid;

    rr_hold_arbiter #(.N_REQ(N), .MAX_HOLD(MH)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_cg       (i_cg),
        .i_req      (i_req),
        .o_gnt      (o_gnt),
        .o_gntIdx   (o_gntIdx),
        .o_gntValid (o_gntValid)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: owner index (-1 = nobody), priority pointer, hold count.
    int m_own  = -1;
    int m_ptr  = 0;
    int m_hold = 0;

    function automatic int pick(input logic [3:0] c);
        for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (c[j]) return j;
        end
        return -1;
    endfunction

    task automatic m_grant(input int k);
        m_own  = k;
        m_ptr  = (k + 1) % N;
        m_hold = 0;
    endtask

    task automatic m_reset();
        m_own  = -1;
        m_ptr  = 0;
        m_hold = 0;
    endtask

    task automatic m_edge(input logic [3:0] req);
        logic [3:0] others;
        others = req;
        if (m_own >= 0) others[m_own] = 1'b0;
        if (m_own < 0) begin
            if (req != 0) m_grant(pick(req));
        end else if (!req[m_own]) begin
            if (others != 0) m_grant(pick(others));
            else m_own = -1;
        end else if (m_hold < MH - 1) begin
            m_hold++;
        end else if (others != 0) begin
            m_grant(pick(others));
        end
    endtask

    task automatic chk_model(input string ph);
        logic [3:0] eg;
        eg = (m_own < 0) ? 4'b0 : (4'b1 << m_own);
        chk({ph, ".gnt"}, 32'(o_gnt), 32'(eg));
        chk({ph, ".idx"}, 32'(o_gntIdx), (m_own < 0) ? 0 : m_own);
        chk({ph, ".vld"}, 32'(o_gntValid), 32'(m_own >= 0));
    endtask

    // Advance one clock, update the model with the inputs seen at that edge,
    // then compare just after the edge.
    task automatic step(input string ph);
        @(posedge i_clk);
        if (!i_rst_n) m_reset();
        else if (i_cg) m_edge(i_req);
        #1;
        chk_model(ph);
    endtask

    initial begin
        // Reset state
        #12;
        chk_model("rst");
        chk("rst.ptr", 32'(dut.ptr), 0);
        chk("rst.hold", 32'(dut.hold_cnt), 0);

        // Basic grant, then handoff without a bubble
        i_rst_n = 1'b1;
        i_req   = 4'b0101;
        step("basic0");
        chk("basic0.dir", 32'(o_gnt), 32'h1);
        i_req = 4'b0100;
        step("basic1");
        chk("basic1.dir", 32'(o_gnt), 32'h4);
        chk("basic1.idxdir", 32'(o_gntIdx), 2);

        // Everybody requesting: rotation with preemption every MH cycles
        i_req = 4'b1111;
        for (int i = 0; i < 15; i++) step("all");

        // Lone requester keeps the grant; hold counter saturates
        i_req = 4'b0010;
        for (int i = 0; i < 10; i++) step("lone");
        chk("lone.dir", 32'(o_gnt), 32'h2);
        chk("lone.hold", 32'(dut.hold_cnt), MH - 1);

        // Owner drops with nobody waiting -> idle
        i_req = 4'b0000;
        step("drop");
        chk("drop.vld", 32'(o_gntValid), 0);

        // Clock gate low: nothing moves while requests churn
        i_req = 4'b1111;
        step("cgpre");
        i_cg = 1'b0;
        for (int i = 0; i < 5; i++) begin
            i_req = 4'($urandom_range(0, 15));
            step("cgoff");
        end
        i_cg  = 1'b1;
        i_req = 4'b1111;
        for (int i = 0; i < 6; i++) step("cgon");

        // Reset mid-grant drops the grant without a clock edge
        chk("prerst.vld", 32'(o_gntValid), 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        m_reset();
        chk("arst.gnt", 32'(o_gnt), 0);
        chk("arst.vld", 32'(o_gntValid), 0);
        chk("arst.ptr", 32'(dut.ptr), 0);
        step("inrst");
        i_rst_n = 1'b1;
        i_req   = 4'b1000;
        step("postrst");
        chk("postrst.dir", 32'(o_gnt), 32'h8);
        chk("postrst.idxdir", 32'(o_gntIdx), 3);

        // Random traffic: requests change occasionally so holds get exercised
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) i_req = 4'($urandom_range(0, 15));
            i_cg = ($urandom_range(0, 7) != 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
